// File: rtl/ucore_output_channels.sv
// ucore_output_channels: buffers ucore results in a small FIFO and multicasts
// the head token to every enabled NoC destination. The head is held until all
// enabled destinations have accepted it, possibly on different cycles.
module ucore_output_channels #(
  parameter int unsigned DATA_WIDTH          = 32,
  parameter int unsigned N                   = 2,
  parameter int unsigned OUTPUT_BUFFER_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          dest_mask,
  input  logic                  core_ivalid,
  input  logic [DATA_WIDTH-1:0] core_in,
  output logic                  core_oready,
  output logic [N-1:0]          noc_ovalid,
  output logic [DATA_WIDTH-1:0] noc_out,
  input  logic [N-1:0]          noc_iready
);

  localparam int unsigned DEPTH = OUTPUT_BUFFER_DEPTH;
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [N-1:0]          sent_q, sent_d;

  logic                  not_empty;
  logic                  push;
  logic                  pop;
  logic [N-1:0]          xfer;
  logic [N-1:0]          done;

  // Handshake outputs and per-destination completion, all derived from state
  always_comb begin
    not_empty   = (count_q != '0);
    core_oready = !rst && (count_q != CNT_FULL);
    noc_ovalid  = {N{not_empty}} & dest_mask & ~sent_q;
    noc_out     = mem_q[rptr_q];
    xfer        = noc_ovalid & noc_iready;
    done        = ~dest_mask | sent_q | xfer;
    push        = core_ivalid && core_oready;
    pop         = not_empty && (&done);
  end

  // Next-state for pointers, occupancy and the sent tracking bits
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    sent_d  = sent_q;

    if (push) begin
      wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + PW'(1);
    end

    if (pop) begin
      rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + PW'(1);
      sent_d = '0;
    end else if (not_empty) begin
      sent_d = sent_q | xfer;
    end

    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // State and storage registers; reset clears everything, including the buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      sent_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[PW'(i)] <= '0;
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      sent_q  <= sent_d;
      if (push) begin
        mem_q[wptr_q] <= core_in;
      end
    end
  end

endmodule

// File: tb/tb_ucore_output_channels.sv
// Testbench for ucore_output_channels: directed scenarios plus a randomized
// run, each compared against a queue-based model of the multicast buffer.
module tb_ucore_output_channels;

  localparam int unsigned DW    = 32;
  localparam int unsigned N     = 2;
  localparam int unsigned DEPTH = 2;

  logic          clk;
  logic          rst;
  logic [N-1:0]  dest_mask;
  logic          core_ivalid;
  logic [DW-1:0] core_in;
  logic          core_oready;
  logic [N-1:0]  noc_ovalid;
  logic [DW-1:0] noc_out;
  logic [N-1:0]  noc_iready;

  int checks = 0;
  int errors = 0;

  // model: FIFO of pending tokens plus destinations that already took the head
  logic [DW-1:0] mq[$];
  logic [N-1:0]  msent;

  // expectations for the current cycle
  logic          er;
  logic [N-1:0]  ev;
  logic [DW-1:0] eo;
  bit            ec;

  logic [DW-1:0] delivered[$];

  ucore_output_channels #(
    .DATA_WIDTH(DW),
    .N(N),
    .OUTPUT_BUFFER_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .dest_mask(dest_mask),
    .core_ivalid(core_ivalid),
    .core_in(core_in),
    .core_oready(core_oready),
    .noc_ovalid(noc_ovalid),
    .noc_out(noc_out),
    .noc_iready(noc_iready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    mq.delete();
    msent = '0;
  endtask

  task automatic model_peek();
    ec = (mq.size() != 0);
    er = (mq.size() != DEPTH);
    ev = ec ? (dest_mask & ~msent) : '0;
    eo = ec ? mq[0] : '0;
  endtask

  // apply the rules for the coming clock edge using the currently driven inputs
  task automatic model_commit();
    logic [N-1:0] xf;
    model_peek();
    xf = ev & noc_iready;
    if (ec && ((msent | xf | ~dest_mask) == {N{1'b1}})) begin
      void'(mq.pop_front());
      msent = '0;
    end else if (ec) begin
      msent = msent | xf;
    end
    if (core_ivalid && er) mq.push_back(core_in);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dest_mask = 2'b11;
    core_ivalid = 1'b0;
    core_in = '0;
    noc_iready = '0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    #1;
    checks += 3;
    if (core_oready !== 1'b0) begin errors++; $display("FAIL reset.oready act=%b exp=0", core_oready); end
    if (noc_ovalid !== 2'b00) begin errors++; $display("FAIL reset.ovalid act=%b exp=00", noc_ovalid); end
    if (noc_out !== 32'h0) begin errors++; $display("FAIL reset.out act=%h exp=0", noc_out); end
    rst = 1'b0;
    #1;
    checks++;
    if (core_oready !== 1'b1) begin errors++; $display("FAIL reset.oready_release act=%b exp=1", core_oready); end
  endtask

  task automatic test_basic();
    logic [N-1:0]  kv [4] = '{2'b00, 2'b11, 2'b11, 2'b00};
    logic [DW-1:0] ko [4] = '{32'h0, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      dest_mask = 2'b11;
      noc_iready = 2'b11;
      core_ivalid = (c < 2);
      core_in = (c == 0) ? 32'hA5A5A5A5 : 32'h5A5A5A5A;
      #1;
      model_peek();
      checks += 3;
      if (core_oready !== er) begin errors++; $display("FAIL basic.oready c=%0d act=%b exp=%b", c, core_oready, er); end
      if (noc_ovalid !== ev) begin errors++; $display("FAIL basic.ovalid c=%0d act=%b exp=%b", c, noc_ovalid, ev); end
      if (noc_ovalid !== kv[c]) begin errors++; $display("FAIL basic.ovalid_const c=%0d act=%b exp=%b", c, noc_ovalid, kv[c]); end
      if (ec) begin
        checks += 2;
        if (noc_out !== eo) begin errors++; $display("FAIL basic.out c=%0d act=%h exp=%h", c, noc_out, eo); end
        if (noc_out !== ko[c]) begin errors++; $display("FAIL basic.out_const c=%0d act=%h exp=%h", c, noc_out, ko[c]); end
      end
      model_commit();
    end
  endtask

  task automatic test_skewed();
    logic [N-1:0] rd [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [N-1:0] kv [4] = '{2'b00, 2'b11, 2'b10, 2'b00};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      dest_mask = 2'b11;
      noc_iready = rd[c];
      core_ivalid = (c == 0);
      core_in = 32'h11111111;
      #1;
      model_peek();
      checks += 3;
      if (core_oready !== er) begin errors++; $display("FAIL skew.oready c=%0d act=%b exp=%b", c, core_oready, er); end
      if (noc_ovalid !== ev) begin errors++; $display("FAIL skew.ovalid c=%0d act=%b exp=%b", c, noc_ovalid, ev); end
      if (noc_ovalid !== kv[c]) begin errors++; $display("FAIL skew.ovalid_const c=%0d act=%b exp=%b", c, noc_ovalid, kv[c]); end
      if (ec) begin
        checks++;
        if (noc_out !== 32'h11111111) begin errors++; $display("FAIL skew.out c=%0d act=%h exp=11111111", c, noc_out); end
      end
      model_commit();
    end
  endtask

  task automatic test_backpressure();
    int k = 0;
    delivered.delete();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      dest_mask = 2'b11;
      noc_iready = (c < 4) ? 2'b00 : 2'b11;
      core_ivalid = (k < 3);
      core_in = 32'h10000000 + DW'(k);
      #1;
      model_peek();
      checks += 2;
      if (core_oready !== er) begin errors++; $display("FAIL bp.oready c=%0d act=%b exp=%b", c, core_oready, er); end
      if (noc_ovalid !== ev) begin errors++; $display("FAIL bp.ovalid c=%0d act=%b exp=%b", c, noc_ovalid, ev); end
      if (ec) begin
        checks++;
        if (noc_out !== eo) begin errors++; $display("FAIL bp.out c=%0d act=%h exp=%h", c, noc_out, eo); end
      end
      if (c == 2) begin
        checks++;
        if (core_oready !== 1'b0) begin errors++; $display("FAIL bp.full act=%b exp=0", core_oready); end
      end
      if (noc_ovalid[0] && noc_iready[0]) delivered.push_back(noc_out);
      if (core_ivalid && er) k++;
      model_commit();
    end
    checks++;
    if (delivered.size() != 3) begin
      errors++; $display("FAIL bp.count act=%0d exp=3", delivered.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (delivered[i] !== 32'h10000000 + DW'(i)) begin
          errors++; $display("FAIL bp.order i=%0d act=%h exp=%h", i, delivered[i], 32'h10000000 + DW'(i));
        end
      end
    end
  endtask

  task automatic test_masking();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      dest_mask = (c < 3) ? 2'b10 : 2'b00;
      noc_iready = 2'b10;
      core_ivalid = (c == 0) || (c >= 4 && c <= 6);
      core_in = (c == 0) ? 32'hCAFEF00D : 32'hB0000000 + DW'(c);
      #1;
      model_peek();
      checks += 3;
      if (core_oready !== er) begin errors++; $display("FAIL mask.oready c=%0d act=%b exp=%b", c, core_oready, er); end
      if (noc_ovalid !== ev) begin errors++; $display("FAIL mask.ovalid c=%0d act=%b exp=%b", c, noc_ovalid, ev); end
      if (noc_ovalid[0] !== 1'b0) begin errors++; $display("FAIL mask.ovalid0 c=%0d act=%b exp=0", c, noc_ovalid[0]); end
      if (c == 1) begin
        checks += 2;
        if (noc_ovalid !== 2'b10) begin errors++; $display("FAIL mask.ovalid_const act=%b exp=10", noc_ovalid); end
        if (noc_out !== 32'hCAFEF00D) begin errors++; $display("FAIL mask.out act=%h exp=cafef00d", noc_out); end
      end
      model_commit();
    end
  endtask

  task automatic test_full_stream();
    int k = 0;
    delivered.delete();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      dest_mask = 2'b11;
      noc_iready = (c < 2) ? 2'b00 : 2'b11;
      core_ivalid = (k < 6);
      core_in = 32'h20000000 + DW'(k);
      #1;
      model_peek();
      checks += 2;
      if (core_oready !== er) begin errors++; $display("FAIL full.oready c=%0d act=%b exp=%b", c, core_oready, er); end
      if (noc_ovalid !== ev) begin errors++; $display("FAIL full.ovalid c=%0d act=%b exp=%b", c, noc_ovalid, ev); end
      if (ec) begin
        checks++;
        if (noc_out !== eo) begin errors++; $display("FAIL full.out c=%0d act=%h exp=%h", c, noc_out, eo); end
      end
      if (noc_ovalid[1] && noc_iready[1]) delivered.push_back(noc_out);
      if (core_ivalid && er) k++;
      model_commit();
    end
    checks++;
    if (delivered.size() != 6) begin
      errors++; $display("FAIL full.count act=%0d exp=6", delivered.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (delivered[i] !== 32'h20000000 + DW'(i)) begin
          errors++; $display("FAIL full.order i=%0d act=%h exp=%h", i, delivered[i], 32'h20000000 + DW'(i));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (mq.size() == 0 && $urandom_range(7) == 0) begin
        dest_mask = N'($urandom);
        core_ivalid = 1'b0;
      end else begin
        core_ivalid = ($urandom_range(3) != 0);
      end
      core_in = $urandom;
      noc_iready = N'($urandom);
      #1;
      model_peek();
      checks += 2;
      if (core_oready !== er) begin errors++; $display("FAIL rand.oready c=%0d act=%b exp=%b", c, core_oready, er); end
      if (noc_ovalid !== ev) begin errors++; $display("FAIL rand.ovalid c=%0d act=%b exp=%b", c, noc_ovalid, ev); end
      if (ec) begin
        checks++;
        if (noc_out !== eo) begin errors++; $display("FAIL rand.out c=%0d act=%h exp=%h", c, noc_out, eo); end
      end
      model_commit();
    end
    // drain so the next scenario starts empty
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      core_ivalid = 1'b0;
      noc_iready = 2'b11;
      #1;
      model_commit();
    end
    checks++;
    if (mq.size() != 0 || noc_ovalid !== 2'b00) begin
      errors++; $display("FAIL rand.drain act=%b exp=00", noc_ovalid);
    end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] rd [3] = '{2'b00, 2'b00, 2'b01};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      dest_mask = 2'b11;
      noc_iready = rd[c];
      core_ivalid = (c < 2);
      core_in = 32'h30000000 + DW'(c);
      #1;
      model_peek();
      checks += 2;
      if (core_oready !== er) begin errors++; $display("FAIL rmid.oready c=%0d act=%b exp=%b", c, core_oready, er); end
      if (noc_ovalid !== ev) begin errors++; $display("FAIL rmid.ovalid c=%0d act=%b exp=%b", c, noc_ovalid, ev); end
      model_commit();
    end
    @(negedge clk);
    core_ivalid = 1'b0;
    noc_iready = 2'b00;
    #1;
    checks++;
    if (noc_ovalid !== 2'b10) begin errors++; $display("FAIL rmid.pre_sent act=%b exp=10", noc_ovalid); end
    #1;
    rst = 1'b1;
    #1;
    checks += 3;
    if (noc_ovalid !== 2'b00) begin errors++; $display("FAIL rmid.ovalid act=%b exp=00", noc_ovalid); end
    if (noc_out !== 32'h0) begin errors++; $display("FAIL rmid.out act=%h exp=0", noc_out); end
    if (core_oready !== 1'b0) begin errors++; $display("FAIL rmid.oready act=%b exp=0", core_oready); end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    #1;
    checks += 2;
    if (core_oready !== 1'b1) begin errors++; $display("FAIL rmid.oready_rel act=%b exp=1", core_oready); end
    if (noc_ovalid !== 2'b00) begin errors++; $display("FAIL rmid.ovalid_rel act=%b exp=00", noc_ovalid); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      dest_mask = 2'b11;
      noc_iready = 2'b11;
      core_ivalid = (c == 0);
      core_in = 32'hDEADBEEF;
      #1;
      model_peek();
      checks += 2;
      if (noc_ovalid !== ev) begin errors++; $display("FAIL rmid.post_ovalid c=%0d act=%b exp=%b", c, noc_ovalid, ev); end
      if (c == 1) begin
        if (noc_out !== 32'hDEADBEEF || noc_ovalid !== 2'b11) begin
          errors++; $display("FAIL rmid.post_out act=%h/%b exp=deadbeef/11", noc_out, noc_ovalid);
        end
      end else begin
        if (noc_ovalid !== 2'b00) begin errors++; $display("FAIL rmid.stale c=%0d act=%b exp=00", c, noc_ovalid); end
      end
      model_commit();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skewed();
    test_backpressure();
    test_masking();
    test_full_stream();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
